// File: rtl/decode_stage.sv
// Registered valid/ready instruction decode stage: splits a 32-bit word into
// fields and class flags, with backpressure, flush, HALT latch and counter.
module decode_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SP_REG     = 16,
  parameter int unsigned LOGIC_ZEXT = 0,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  input  logic             resume,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [XLEN-1:0]  imm,
  output logic             is_branch,
  output logic             is_load,
  output logic             is_store,
  output logic             uses_sp,
  output logic             is_halt,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] dec_count
);

  localparam logic [5:0] OP_REG  = 6'h00;
  localparam logic [5:0] OP_ANDI = 6'h03;
  localparam logic [5:0] OP_ORI  = 6'h04;
  localparam logic [5:0] OP_XORI = 6'h05;
  localparam logic [5:0] OP_SLAI = 6'h07;
  localparam logic [5:0] OP_SRLI = 6'h08;
  localparam logic [5:0] OP_SRAI = 6'h09;
  localparam logic [5:0] OP_BR   = 6'h0A;
  localparam logic [5:0] OP_BZ   = 6'h0D;
  localparam logic [5:0] OP_LD   = 6'h0E;
  localparam logic [5:0] OP_ST   = 6'h0F;
  localparam logic [5:0] OP_U10  = 6'h10;
  localparam logic [5:0] OP_U11  = 6'h11;
  localparam logic [5:0] OP_MOVE = 6'h12;
  localparam logic [5:0] OP_PUSH = 6'h13;
  localparam logic [5:0] OP_POP  = 6'h14;
  localparam logic [5:0] OP_CALL = 6'h15;
  localparam logic [5:0] OP_HALT = 6'h16;
  localparam logic [5:0] OP_NOP  = 6'h17;
  localparam logic [5:0] OP_RET  = 6'h18;
  localparam logic [5:0] OP_NORI = 6'h19;
  localparam logic [5:0] OP_U1C  = 6'h1C;
  localparam logic [4:0] SP_IDX  = 5'(SP_REG);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm;
    logic            is_branch;
    logic            is_load;
    logic            is_store;
    logic            uses_sp;
    logic            is_halt;
    logic            illegal;
  } dec_t;

  dec_t            dec;
  dec_t            q;
  state_t          state;
  logic            accept;
  logic            logic_op;
  logic [XLEN-1:0] ext;

  assign in_ready = !rst && !flush && (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Immediate extension; logic ops may zero-extend by configuration
  assign logic_op = (dec.op == OP_ANDI) || (dec.op == OP_ORI) ||
                    (dec.op == OP_XORI) || (dec.op == OP_NORI);
  assign ext = (LOGIC_ZEXT != 0 && logic_op) ? XLEN'(instr[15:0])
                                             : XLEN'($signed(instr[15:0]));

  // Combinational field decode of the incoming word
  always_comb begin
    dec    = '0;
    dec.op = instr[31:26];
    case (dec.op)
      OP_REG: begin
        dec.rs    = instr[25:21];
        dec.rt    = instr[20:16];
        dec.rd    = instr[15:11];
        dec.shamt = instr[10:6];
        dec.funct = instr[5:0];
      end
      OP_PUSH, OP_POP: begin
        dec.rs = SP_IDX;
        dec.rd = SP_IDX;
        dec.rt = instr[25:21];
      end
      OP_CALL: begin
        dec.rs  = SP_IDX;
        dec.rd  = SP_IDX;
        dec.imm = ext;
      end
      OP_RET: begin
        dec.rs = SP_IDX;
        dec.rd = SP_IDX;
      end
      OP_HALT, OP_NOP: ;
      default: begin
        dec.rs = instr[25:21];
        dec.rt = instr[20:16];
        if (dec.op == OP_SLAI || dec.op == OP_SRLI || dec.op == OP_SRAI)
          dec.shamt = instr[4:0];
        if (dec.op != OP_MOVE)
          dec.imm = ext;
      end
    endcase
    dec.is_branch = (dec.op >= OP_BR) && (dec.op <= OP_BZ);
    dec.is_load   = (dec.op == OP_LD);
    dec.is_store  = (dec.op == OP_ST);
    dec.uses_sp   = (dec.op == OP_PUSH) || (dec.op == OP_POP) ||
                    (dec.op == OP_CALL) || (dec.op == OP_RET);
    dec.is_halt   = (dec.op == OP_HALT);
    dec.illegal   = (dec.op == OP_U10) || (dec.op == OP_U11) || (dec.op >= OP_U1C);
  end

  // Output register, handshake, halt state and accept counter
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      out_valid <= 1'b0;
      state     <= RUN;
      dec_count <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        q         <= dec;
        out_valid <= 1'b1;
        dec_count <= dec_count + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        RUN:    if (accept && dec.is_halt) state <= HALTED;
        HALTED: if (resume) state <= RUN;
      endcase
    end
  end

  assign halted    = (state == HALTED);
  assign op        = q.op;
  assign funct     = q.funct;
  assign rs        = q.rs;
  assign rt        = q.rt;
  assign rd        = q.rd;
  assign shamt     = q.shamt;
  assign imm       = q.imm;
  assign is_branch = q.is_branch;
  assign is_load   = q.is_load;
  assign is_store  = q.is_store;
  assign uses_sp   = q.uses_sp;
  assign is_halt   = q.is_halt;
  assign illegal   = q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction decode stage for the 32-bit core. It accepts one fetched instruction per cycle over a valid/ready interface and splits it into op, funct, register indices, shift amount and an XLEN-wide immediate, plus class flags. It holds the result in an output register until the execute stage takes it. It sits between fetch and register-file read, and adds over a purely combinational decoder: backpressure, flush, a HALT latch, illegal-opcode detection, a configurable stack-pointer register and a configurable immediate extension mode.

## Interface
- XLEN, 32: immediate output width; must be at least 16.
- SP_REG, 16: register index substituted for rs/rd by PUSH/POP/CALL/RET.
- LOGIC_ZEXT, 0: when 1, ANDI/ORI/XORI/NORI zero-extend the immediate; when 0, all immediates sign-extend.
- CNT_W, 32: width of the accepted-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage can accept instr this cycle.
- instr  in  32  instruction word.
- flush  in  1  drop the output entry and block acceptance this cycle.
- resume  in  1  clear the halted state.
- out_valid  out  1  decoded entry is valid.
- out_ready  in  1  consumer takes the entry.
- op, funct  out  6 each  opcode and function fields.
- rs, rt, rd, shamt  out  5 each  register indices and shift amount.
- imm  out  XLEN  extended immediate.
- is_branch, is_load, is_store, uses_sp, is_halt, illegal  out  1 each  instruction class flags.
- halted  out  1  HALT has been accepted and resume has not yet been seen.
- dec_count  out  CNT_W  number of accepted instructions; wraps to 0.

## Operation
Opcodes:
- REG 00; ADDI 01, SUBI 02, ANDI 03, ORI 04, XORI 05, NOTI 06, SLAI 07, SRLI 08, SRAI 09, NORI 19, SLTI 1A, SGTI 1B.
- BR 0A, BMI 0B, BPL 0C, BZ 0D; LD 0E; ST 0F; MOVE 12.
- PUSH 13, POP 14, CALL 15, HALT 16, NOP 17, RET 18 (all hex).

Field decode (every field not listed below is 0):
- REG: rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=0.
- PUSH/POP: rs=rd=SP_REG, rt=[25:21], imm=0.
- CALL: rs=rd=SP_REG, rt=0, imm=ext([15:0]).
- RET: rs=rd=SP_REG.
- HALT/NOP: all fields 0.
- All other opcodes: rs=[25:21], rt=[20:16], rd=0, funct=0.
  - shamt=[4:0] for SLAI/SRLI/SRAI, otherwise 0.
  - imm=0 for MOVE (executed as ADDI with immediate 0), otherwise ext([15:0]).
- ext: sign-extension to XLEN, i.e. replicate bit 15. Zero-extension instead for the logic ops when LOGIC_ZEXT=1.
- Undefined opcodes are 10, 11 and 1C–3F.
  - They raise illegal=1 and are decoded with the "all other opcodes" rule.
  - They are otherwise passed through; trapping is execute's job.

Flags:
- is_branch for 0A–0D; is_load for 0E; is_store for 0F.
- uses_sp for 13/14/15/18; is_halt for 16.

Control:
- in_ready = !rst && !flush && !halted && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, the output register loads the decoded fields, out_valid becomes 1 and dec_count increments.
- out_valid clears when out_valid && out_ready && !accept, or on flush.
- Halt FSM:
  - RUN → HALTED on accepting HALT. The HALT entry itself is still presented on the outputs.
  - HALTED → RUN on resume.
  - resume while in RUN has no effect.
- flush and resume in the same cycle: both take effect. Next cycle out_valid=0 and the state is RUN.
- The output register holds its value while out_valid && !out_ready; a stalled entry is never overwritten.

## Timing
- Latency: one cycle, from an accept edge to out_valid=1 with the fields valid.
- Full throughput of one instruction per cycle when out_ready stays high.
- in_ready is combinational from out_ready, flush and the internal state. There is no combinational path from instr to any output.
- Reset, at the first edge with rst=1: out_valid=0, halted=0, dec_count=0, and all field and flag outputs 0. in_ready is 0 while rst=1.
- Reset in the middle of a stall drops the held entry; nothing is carried across reset.
- flush at cycle N: no accept at N; out_valid=0 after edge N.
- dec_count wraps from 2^CNT_W−1 to 0.

## Test plan
- ADDI, instr=0x0443FFFC with in_valid=1 and out_ready=1 → next cycle op=01, rs=2, rt=3, rd=0, imm=0xFFFFFFFC, illegal=0.
- PUSH r5, instr=0x4CA00000 → rs=16, rt=5, rd=16, uses_sp=1. Repeat with SP_REG=29 → rs=rd=29.
- SRAI, instr=0x24220003 → shamt=3, imm=3. ORI, instr=0x1022_8000:
  - LOGIC_ZEXT=0 → imm=0xFFFF8000.
  - LOGIC_ZEXT=1 → imm=0x00008000.
- Backpressure: 4 back-to-back instructions with out_ready low for 3 cycles → in_ready=0 during the stall, the outputs are stable, no entry is lost or duplicated, and dec_count=4.
- HALT, instr=0x58000000 → is_halt=1, then halted=1 and in_ready=0. resume pulse → in_ready=1 the next cycle. Also: flush together with resume.
- Illegal opcode, instr=0x40000000 → illegal=1. Then an rst pulse while stalled → out_valid=0 and dec_count=0.
